// File: rtl/case_3_sdiv_7s_5s_7_seq_1_if.sv
// Handshake and data bundle for the sequential signed divider.
//   ce    : clock enable, all divider registers hold while low
//   start : operand-valid pulse, sampled only while ready is high
//   din0  : signed dividend
//   din1  : signed divisor
//   ready : divider is idle and can accept start
//   done  : one enabled cycle pulse when dout/rem update
//   dout  : signed quotient
//   rem   : signed remainder (sign of the dividend)
// master drives the operands, slave is the divider.
interface case_3_sdiv_7s_5s_7_seq_1_if #(
    parameter int din0_WIDTH = 7,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 7
);
    logic                  ce;
    logic                  start;
    logic                  ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  done;
    logic [dout_WIDTH-1:0] dout;
    logic [din1_WIDTH-1:0] rem;

    modport master (
        output ce, start, din0, din1,
        input  ready, done, dout, rem
    );

    modport slave (
        input  ce, start, din0, din1,
        output ready, done, dout, rem
    );
endinterface

// File: rtl/case_3_sdiv_7s_5s_7_seq_1.sv
// Sequential signed divider: one restoring iteration per enabled cycle.
// Truncating quotient, remainder carries the dividend's sign.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of the start/done/ce handshake and operand bundle
// Schedule: accept edge, din0_WIDTH CALC edges, one FIX edge that registers
// dout/rem/done.
module case_3_sdiv_7s_5s_7_seq_1 #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 9,
    parameter int din0_WIDTH = 7,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    case_3_sdiv_7s_5s_7_seq_1_if.slave    bus
);
    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = $clog2(W0 + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W0-1:0]   a_q, a_d;       // dividend bits shift out, quotient bits shift in
    logic [W1-1:0]   b_q, b_d;       // |divisor|
    logic [W1-1:0]   r_q, r_d;       // partial remainder, always < |divisor|
    logic            qsign_q, qsign_d;
    logic            rsign_q, rsign_d;
    logic            div0_q, div0_d;
    logic            done_q, done_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic [W1-1:0]   rem_q, rem_d;

    logic [W0-1:0]   abs0;
    logic [W1-1:0]   abs1;
    logic [W1:0]     shifted;
    logic [W1+1:0]   trial;
    logic            fits;
    logic [W0-1:0]   q_signed;

    logic unused_params;
    assign unused_params = ^{32'(ID), 32'(NUM_STAGE)};

    // |-2^(W-1)| fits the unsigned W-bit magnitude.
    assign abs0 = bus.din0[W0-1] ? W0'(-bus.din0) : bus.din0;
    assign abs1 = bus.din1[W1-1] ? W1'(-bus.din1) : bus.din1;

    // One restoring step: bring in the next dividend bit and trial-subtract.
    assign shifted = {r_q, a_q[W0-1]};
    assign trial   = {1'b0, shifted} - {2'b00, b_q};
    assign fits    = ~trial[W1+1];

    assign q_signed = qsign_q ? W0'(-a_q) : a_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        div0_d  = div0_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        rem_d   = rem_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = abs0;
                    b_d     = abs1;
                    r_d     = '0;
                    cnt_d   = '0;
                    qsign_d = bus.din0[W0-1] ^ bus.din1[W1-1];
                    rsign_d = bus.din0[W0-1];
                    div0_d  = (bus.din1 == '0);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                r_d   = fits ? trial[W1-1:0] : shifted[W1-1:0];
                a_d   = {a_q[W0-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W0 - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (div0_q) begin
                    dout_d = '1;
                    rem_d  = '0;
                end else begin
                    // Truncation makes -2^(W0-1) / -1 wrap back to -2^(W0-1).
                    dout_d = dout_WIDTH'(q_signed);
                    rem_d  = rsign_q ? W1'(-r_q) : r_q;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
        end else if (bus.ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.ready = (state_q == StIdle);
    assign bus.done  = done_q;
    assign bus.dout  = dout_q;
    assign bus.rem   = rem_q;
endmodule
